param_seq_multiplier: RTL

//   Parametrised sequential shift-add multiplier; successor to the fixed 32-bit unsigned

---
 rtl/param_seq_multiplier.sv | 118 +++++++++++
 1 files changed

// File: rtl/param_seq_multiplier.sv
// Multi-cycle shift-add multiplier for MULT/MULTU with signed/unsigned mode.
// Prod is updated only when the sign fix-up completes, so it holds the last result while busy.
module param_seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               Run,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Mult,
  input  logic [WIDTH-1:0]   Mul,
  output logic [2*WIDTH-1:0] Prod,
  output logic               Rdy,
  output logic               Busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Magnitude as an unsigned WIDTH-bit value; the most negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      abs_val = ~x + ONE_W;
    end else begin
      abs_val = x;
    end
  endfunction

  logic [1:0]         state_r, state_nxt_s;
  logic [2*WIDTH-1:0] acc_r, acc_nxt_s;
  logic [WIDTH-1:0]   mcand_r, mcand_nxt_s;
  logic               neg_r, neg_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [2*WIDTH-1:0] prod_r, prod_nxt_s;
  logic               rdy_r, rdy_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [WIDTH:0]     sum_s;

  // Next-state and datapath update for one clock edge.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    mcand_nxt_s = mcand_r;
    neg_nxt_s   = neg_r;
    cnt_nxt_s   = cnt_r;
    prod_nxt_s  = prod_r;
    sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
          + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Run) begin
          mcand_nxt_s = abs_val(Mult, Signed);
          neg_nxt_s   = Signed & (Mult[WIDTH-1] ^ Mul[WIDTH-1]);
          acc_nxt_s   = {{WIDTH{1'b0}}, abs_val(Mul, Signed)};
          cnt_nxt_s   = CNT_INIT;
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CALC: begin
        // Carry of the partial sum enters the MSB as the accumulator shifts right.
        acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_FIX: begin
        prod_nxt_s  = neg_r ? (~acc_r + ONE_2W) : acc_r;
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_CALC) || (state_nxt_s == ST_FIX);
    rdy_nxt_s  = (state_nxt_s == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      rdy_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      mcand_r <= mcand_nxt_s;
      neg_r   <= neg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      prod_r  <= prod_nxt_s;
      rdy_r   <= rdy_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign Prod = prod_r;
  assign Rdy  = rdy_r;
  assign Busy = busy_r;

endmodule
